fir_tap_sequencer: RTL and testbench

// Scheduler for the shared coefficient SpSram / MAC datapath of the 4-module, 10-tap FIR.

---
 rtl/fir_tap_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_fir_tap_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: schedules the shared coefficient RAM and MAC datapath.
// A sample strobe launches one read sweep over all taps; host coefficient
// writes are slotted onto the same single-port RAM between sweeps.
// Every output comes straight from a flop, decoded from the next state.
module fir_tap_sequencer #(
  parameter int NUM_TAPS = 10,
  parameter int ADDR_W   = 4,
  parameter int SEL_W    = 2,
  parameter int DATA_W   = 16
) (
  input  logic                    iClk12M,
  input  logic                    iRst,
  input  logic                    iEnSample600k,
  input  logic                    iWrReq,
  input  logic [SEL_W+ADDR_W-1:0] iWrAddr,
  input  logic [DATA_W-1:0]       iWrData,
  output logic                    oWrAck,
  output logic                    oWrErr,
  output logic                    oCsnRam,
  output logic                    oWrnRam,
  output logic [ADDR_W-1:0]       oAddrRam,
  output logic [SEL_W-1:0]        oModuleSel,
  output logic [DATA_W-1:0]       oWtDtRam,
  output logic                    oEnDelay,
  output logic                    oAccClr,
  output logic                    oEnMul,
  output logic                    oEnAddAcc,
  output logic                    oOutValid,
  output logic                    oBusy,
  output logic                    oOverrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(NUM_TAPS - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   tap_q, tap_d;
  logic                drain_q, drain_d;
  logic                pend_q, pend_d;

  logic                csn_q, csn_d;
  logic                wrn_q, wrn_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic                dly_q, dly_d;
  logic                clr_q, clr_d;
  logic                mul_q, mul_d;
  logic                add_q, add_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                ovr_q, ovr_d;

  logic [ADDR_W-1:0]   wr_tap;
  logic [SEL_W-1:0]    wr_sel;
  logic                wr_bad;

  assign wr_tap = iWrAddr[ADDR_W-1:0];
  assign wr_sel = iWrAddr[SEL_W+ADDR_W-1:ADDR_W];
  // Taps beyond the last one have no RAM word; such writes are acked but flagged.
  assign wr_bad = (32'(wr_tap) >= 32'(NUM_TAPS));

  // Next-state logic: sweep sequencing, write arbitration, pending strobe, overrun.
  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    drain_d = drain_q;
    pend_d  = pend_q;
    // A strobe during any busy cycle is dropped and remembered as overrun.
    ovr_d   = ovr_q | (iEnSample600k & busy_q);
    case (state_q)
      S_IDLE: begin
        if (iEnSample600k || pend_q) begin
          state_d = S_READ;
          tap_d   = '0;
          pend_d  = 1'b0;
        end else if (iWrReq) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
        // Not busy here, so a strobe is kept for the following idle cycle.
        if (iEnSample600k) pend_d = 1'b1;
      end
      S_READ: begin
        if (tap_q == LAST_TAP) begin
          state_d = S_DRAIN;
          drain_d = 1'b0;
        end else begin
          tap_d = tap_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q) state_d = S_DONE;
        else         drain_d = 1'b1;
      end
      S_DONE: begin
        // Last busy cycle: strobes are dropped, but a waiting write may go next.
        state_d = iWrReq ? S_WRITE : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state so the registered outputs line up with it.
  always_comb begin
    csn_d   = 1'b1;
    wrn_d   = 1'b1;
    addr_d  = '0;
    sel_d   = '0;
    wdata_d = '0;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dly_d   = 1'b0;
    clr_d   = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    // RAM data arrives one cycle after the read address; accumulate one after that.
    mul_d   = (state_q == S_READ);
    add_d   = mul_q;
    case (state_d)
      S_WRITE: begin
        csn_d   = wr_bad;
        wrn_d   = 1'b0;
        addr_d  = wr_tap;
        sel_d   = wr_sel;
        wdata_d = iWrData;
        ack_d   = 1'b1;
        err_d   = wr_bad;
      end
      S_READ: begin
        csn_d  = 1'b0;
        addr_d = tap_d;
        busy_d = 1'b1;
        if (state_q != S_READ) begin
          dly_d = 1'b1;
          clr_d = 1'b1;
        end
      end
      S_DRAIN: busy_d = 1'b1;
      S_DONE: begin
        busy_d  = 1'b1;
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge iClk12M) begin
    if (iRst) begin
      state_q <= S_IDLE;
      tap_q   <= '0;
      drain_q <= 1'b0;
      pend_q  <= 1'b0;
      csn_q   <= 1'b1;
      wrn_q   <= 1'b1;
      addr_q  <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dly_q   <= 1'b0;
      clr_q   <= 1'b0;
      mul_q   <= 1'b0;
      add_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      drain_q <= drain_d;
      pend_q  <= pend_d;
      csn_q   <= csn_d;
      wrn_q   <= wrn_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dly_q   <= dly_d;
      clr_q   <= clr_d;
      mul_q   <= mul_d;
      add_q   <= add_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

  assign oWrAck     = ack_q;
  assign oWrErr     = err_q;
  assign oCsnRam    = csn_q;
  assign oWrnRam    = wrn_q;
  assign oAddrRam   = addr_q;
  assign oModuleSel = sel_q;
  assign oWtDtRam   = wdata_q;
  assign oEnDelay   = dly_q;
  assign oAccClr    = clr_q;
  assign oEnMul     = mul_q;
  assign oEnAddAcc  = add_q;
  assign oOutValid  = valid_q;
  assign oBusy      = busy_q;
  assign oOverrun   = ovr_q;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer: a write table, hand-written sweep sequences and
// a randomized run, all checked every cycle against a timestamp-based model.
module tb_fir_tap_sequencer;

  localparam int NT = 10;

  logic        clk = 1'b0;
  logic        iRst, iEnSample600k, iWrReq;
  logic [5:0]  iWrAddr;
  logic [15:0] iWrData;
  logic        oWrAck, oWrErr, oCsnRam, oWrnRam;
  logic [3:0]  oAddrRam;
  logic [1:0]  oModuleSel;
  logic [15:0] oWtDtRam;
  logic        oEnDelay, oAccClr, oEnMul, oEnAddAcc, oOutValid, oBusy, oOverrun;

  always #5 clk = ~clk;

  fir_tap_sequencer dut (
    .iClk12M(clk), .iRst(iRst), .iEnSample600k(iEnSample600k),
    .iWrReq(iWrReq), .iWrAddr(iWrAddr), .iWrData(iWrData),
    .oWrAck(oWrAck), .oWrErr(oWrErr), .oCsnRam(oCsnRam), .oWrnRam(oWrnRam),
    .oAddrRam(oAddrRam), .oModuleSel(oModuleSel), .oWtDtRam(oWtDtRam),
    .oEnDelay(oEnDelay), .oAccClr(oAccClr), .oEnMul(oEnMul),
    .oEnAddAcc(oEnAddAcc), .oOutValid(oOutValid), .oBusy(oBusy),
    .oOverrun(oOverrun)
  );

  typedef struct packed {
    logic        csn;
    logic        wrn;
    logic [3:0]  addr;
    logic [1:0]  sel;
    logic [15:0] wdata;
    logic        ack;
    logic        err;
    logic        dly;
    logic        clr;
    logic        mul;
    logic        add;
    logic        valid;
    logic        busy;
    logic        ovr;
  } outs_t;

  typedef struct {
    logic [5:0]  a;
    logic [15:0] d;
    logic        csn;
    logic [1:0]  sel;
    logic [3:0]  addr;
    logic        err;
  } wvec_t;

  int vectors = 0;
  int miscompares = 0;

  // Model: a sweep is a start timestamp, a write is a grant timestamp.
  int         mt = 0;
  int         ms = -1000;
  int         mg = -1000;
  bit         mpend = 1'b0;
  bit         movr = 1'b0;
  logic [5:0] ga = '0;
  logic [15:0] gd = '0;

  function automatic outs_t idle_outs();
    outs_t o;
    o = '0;
    o.csn = 1'b1;
    o.wrn = 1'b1;
    return o;
  endfunction

  // Outputs k cycles after the strobe that started the sweep.
  function automatic outs_t sweep_outs(input int k);
    outs_t o;
    o = idle_outs();
    o.busy = 1'b1;
    if (k <= NT) begin
      o.csn  = 1'b0;
      o.addr = 4'(k - 1);
    end
    o.dly   = (k == 1);
    o.clr   = (k == 1);
    o.mul   = (k >= 2 && k <= NT + 1);
    o.add   = (k >= 3 && k <= NT + 2);
    o.valid = (k == NT + 3);
    return o;
  endfunction

  function automatic outs_t write_outs(input logic [5:0] a, input logic [15:0] d);
    outs_t o;
    int    tap;
    tap = int'(a[3:0]);
    o = idle_outs();
    o.wrn   = 1'b0;
    o.addr  = a[3:0];
    o.sel   = a[5:4];
    o.wdata = d;
    o.ack   = 1'b1;
    o.err   = (tap >= NT);
    o.csn   = (tap >= NT);
    return o;
  endfunction

  // Decide what happens with the inputs at model time mt; return outputs for mt+1.
  function automatic outs_t model_step(input bit stb, input bit wr,
                                       input logic [5:0] a, input logic [15:0] d);
    outs_t e;
    bit    busy_now;
    bit    wr_now;
    int    k;
    busy_now = (mt >= ms + 1) && (mt <= ms + NT + 3);
    wr_now   = (mt == mg + 1);
    if (busy_now) begin
      if (stb) movr = 1'b1;
      if (mt == ms + NT + 3 && wr) begin
        mg = mt; ga = a; gd = d;
      end
    end else if (wr_now) begin
      if (stb) mpend = 1'b1;
    end else if (stb || mpend) begin
      ms = mt;
      mpend = 1'b0;
    end else if (wr) begin
      mg = mt; ga = a; gd = d;
    end
    k = mt + 1 - ms;
    if (k >= 1 && k <= NT + 3) e = sweep_outs(k);
    else if (mg == mt)         e = write_outs(ga, gd);
    else                       e = idle_outs();
    e.ovr = movr;
    return e;
  endfunction

  function automatic outs_t get_act();
    outs_t g;
    g.csn = oCsnRam;   g.wrn = oWrnRam;    g.addr = oAddrRam;  g.sel = oModuleSel;
    g.wdata = oWtDtRam; g.ack = oWrAck;    g.err = oWrErr;     g.dly = oEnDelay;
    g.clr = oAccClr;   g.mul = oEnMul;     g.add = oEnAddAcc;  g.valid = oOutValid;
    g.busy = oBusy;    g.ovr = oOverrun;
    return g;
  endfunction

  // One clock: drive inputs, advance the model, compare every output after the edge.
  task automatic cycle(input bit stb, input bit wr, input logic [5:0] a,
                       input logic [15:0] d, input bit rst, input string tag);
    outs_t e;
    outs_t g;
    iEnSample600k = stb; iWrReq = wr; iWrAddr = a; iWrData = d; iRst = rst;
    if (rst) begin
      ms = -1000; mg = -1000; mpend = 1'b0; movr = 1'b0;
      e = idle_outs();
    end else begin
      e = model_step(stb, wr, a, d);
    end
    @(posedge clk);
    #1;
    mt++;
    g = get_act();
    vectors++;
    if (g !== e) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h want %h", tag, mt, g, e);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Host write: hold the request until oWrAck; off = cycles from first request to ack.
  task automatic host_write(input bit stb_first, input logic [5:0] a, input logic [15:0] d,
                            input int max, input string tag, output int off);
    off = -1;
    for (int i = 0; i < max; i++) begin
      cycle(stb_first && (i == 0), 1'b1, a, d, 1'b0, tag);
      if (oWrAck === 1'b1) begin
        off = i + 1;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wvec_t wtab[6];
    int    off;
    outs_t want_w;
    bit    wr_act;
    logic [5:0]  ra;
    logic [15:0] rd;
    bit    stb;
    bit    rst;

    wtab[0] = '{a: 6'h25, d: 16'hABCD, csn: 1'b0, sel: 2'd2, addr: 4'h5, err: 1'b0};
    wtab[1] = '{a: 6'h0C, d: 16'h1234, csn: 1'b1, sel: 2'd0, addr: 4'hC, err: 1'b1};
    wtab[2] = '{a: 6'h00, d: 16'h0001, csn: 1'b0, sel: 2'd0, addr: 4'h0, err: 1'b0};
    wtab[3] = '{a: 6'h39, d: 16'hFFFF, csn: 1'b0, sel: 2'd3, addr: 4'h9, err: 1'b0};
    wtab[4] = '{a: 6'h1A, d: 16'h5A5A, csn: 1'b1, sel: 2'd1, addr: 4'hA, err: 1'b1};
    wtab[5] = '{a: 6'h3F, d: 16'h8001, csn: 1'b1, sel: 2'd3, addr: 4'hF, err: 1'b1};

    // Power-on reset.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 6'h0, 16'h0, 1'b1, "reset");
    check_bit("reset_csn", oCsnRam, 1'b1);
    check_bit("reset_wrn", oWrnRam, 1'b1);
    cycle(1'b0, 1'b0, 6'h0, 16'h0, 1'b0, "idle");

    // Write table, including the tap-range boundary.
    for (int i = 0; i < 6; i++) begin
      host_write(1'b0, wtab[i].a, wtab[i].d, 4, "wtab", off);
      check_int("wtab_latency", off, 1);
      want_w = idle_outs();
      want_w.csn = wtab[i].csn; want_w.wrn = 1'b0; want_w.sel = wtab[i].sel;
      want_w.addr = wtab[i].addr; want_w.wdata = wtab[i].d;
      want_w.ack = 1'b1; want_w.err = wtab[i].err;
      vectors++;
      if (get_act() !== want_w) begin
        miscompares++;
        $display("FAIL wtab[%0d]: got %h want %h", i, get_act(), want_w);
      end
      $display("write addr=%h data=%h csn=%b err=%b", wtab[i].a, wtab[i].d, oCsnRam, oWrErr);
      cycle(1'b0, 1'b0, 6'h0, 16'h0, 1'b0, "wtab_gap");
    end

    // Single sweep.
    cycle(1'b1, 1'b0, 6'h0, 16'h0, 1'b0, "t2");
    check_bit("t2_delay_t1", oEnDelay, 1'b1);
    check_bit("t2_accclr_t1", oAccClr, 1'b1);
    for (int k = 2; k <= 14; k++) begin
      cycle(1'b0, 1'b0, 6'h0, 16'h0, 1'b0, "t2");
      if (k == 10) check_bit("t2_csn_t10", oCsnRam, 1'b0);
      if (k == 11) check_bit("t2_mul_t11", oEnMul, 1'b1);
      if (k == 13) check_bit("t2_valid_t13", oOutValid, 1'b1);
      if (k == 14) check_bit("t2_busy_t14", oBusy, 1'b0);
    end
    $display("sweep single done");

    // Strobe and write in the same idle cycle: sweep first, ack at t14.
    host_write(1'b1, 6'h13, 16'h0F0F, 20, "t4", off);
    check_int("t4_ack_offset", off, 14);
    $display("collision write acked at t%0d", off);
    cycle(1'b0, 1'b0, 6'h0, 16'h0, 1'b0, "t4_gap");

    // Overrun: strobes at t0, t8, t20.
    for (int k = 0; k <= 34; k++) begin
      cycle((k == 0) || (k == 8) || (k == 20), 1'b0, 6'h0, 16'h0, 1'b0, "t6");
      if (k + 1 == 8)  check_bit("t6_ovr_t8", oOverrun, 1'b0);
      if (k + 1 == 9)  check_bit("t6_ovr_t9", oOverrun, 1'b1);
      if (k + 1 == 13) check_bit("t6_valid_t13", oOutValid, 1'b1);
      if (k + 1 == 21) check_bit("t6_valid_t21", oOutValid, 1'b0);
      if (k + 1 == 33) check_bit("t6_valid_t33", oOutValid, 1'b1);
    end
    $display("overrun sequence done");

    // Reset held three cycles in the middle of a sweep.
    for (int k = 0; k <= 20; k++) begin
      cycle((k == 0) || (k == 3), 1'b0, 6'h0, 16'h0, (k >= 5) && (k <= 7), "t1");
      if (k + 1 == 6) begin
        check_bit("t1_csn_after_rst", oCsnRam, 1'b1);
        check_bit("t1_busy_after_rst", oBusy, 1'b0);
        check_bit("t1_ovr_after_rst", oOverrun, 1'b0);
      end
      if (k + 1 == 13) check_bit("t1_no_valid", oOutValid, 1'b0);
    end
    $display("mid-sweep reset done");

    // Randomized traffic against the model.
    wr_act = 1'b0; ra = '0; rd = '0;
    for (int n = 0; n < 1200; n++) begin
      if (!wr_act && $urandom_range(0, 5) == 0) begin
        wr_act = 1'b1;
        ra = 6'($urandom);
        rd = 16'($urandom);
      end
      stb = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 399) == 0);
      cycle(stb, wr_act, ra, rd, rst, "rand");
      if (rst) wr_act = 1'b0;
      if (wr_act && oWrAck === 1'b1) begin
        wr_act = 1'b0;
        $display("rand write addr=%h data=%h err=%b", ra, rd, oWrErr);
      end
      if (oOutValid === 1'b1) $display("rand sweep done at cycle %0d", mt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
